ddr3_local_burst_master: RTL and testbench

- Initiator for the DDR3 controller's local interface.
- Turns a simple command stream (read/write, address, beat count) plus a write-data stream into legal local-interface burst transactions.
- Returns read beats to the client and tracks outstanding read beats.
- Sits between the graphics memory arbiter and the DDR3 controller/PHY top, in the controller's phy_clk domain.

---
 rtl/ddr3_local_burst_master.sv | 179 +++++++++++++++++
 tb/tb_ddr3_local_burst_master.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_local_burst_master.sv
// ddr3_local_burst_master
//   Initiator for the DDR3 controller local interface. Converts a command
//   stream (read/write, word address, beat count) and a write-data stream
//   into local-interface burst transactions, forwards read beats back to the
//   client and tracks the number of read beats still in flight.
//   Runs entirely in the controller's phy_clk domain.
//
// Optional build macro: DDR3_MASTER_STATS_EN
//   Adds stat_clr (in) and the 32-bit wrapping counters stat_rd_beats,
//   stat_wr_beats and stat_stall (out).
//
// Ports
//   clk, reset            phy_clk, synchronous active-high reset
//   cmd_*                 command handshake (valid/ready), write flag,
//                         start address, length (0 means 1 beat)
//   wr_data/wr_be/wr_*    write beat stream, consumed on wr_valid && wr_ready
//   rd_data/rd_valid      read beats, one cycle after the controller, no backpressure
//   rd_pending            read beats requested but not yet returned
//   rd_underflow          sticky: a read beat arrived with nothing pending
//   busy                  not idle, or reads still outstanding
//   local_*               controller local interface
module ddr3_local_burst_master #(
  parameter int unsigned ADDR_W          = 24,
  parameter int unsigned DATA_W          = 256,
  parameter int unsigned SIZE_W          = 5,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef DDR3_MASTER_STATS_EN
  input  logic                  stat_clr,
  output logic [31:0]           stat_rd_beats,
  output logic [31:0]           stat_wr_beats,
  output logic [31:0]           stat_stall,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [SIZE_W-1:0]     cmd_len,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic [7:0]            rd_pending,
  output logic                  rd_underflow,
  output logic                  busy,
  output logic [ADDR_W-1:0]     local_address,
  output logic [SIZE_W-1:0]     local_size,
  output logic                  local_burstbegin,
  output logic                  local_read_req,
  output logic                  local_write_req,
  output logic [DATA_W-1:0]     local_wdata,
  output logic [DATA_W/8-1:0]   local_be,
  input  logic                  local_ready,
  input  logic [DATA_W-1:0]     local_rdata,
  input  logic                  local_rdata_valid,
  input  logic                  local_init_done
);

  typedef enum logic [1:0] {
    INIT_WAIT,
    IDLE,
    RD_REQ,
    WR_BURST
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [SIZE_W-1:0]   beat_cnt;
  logic [SIZE_W-1:0]   cmd_len_eff;
  logic [8:0]          rd_sum;
  logic                rd_room;
  logic                accept;
  logic                wr_beat;
  logic                last_beat;
  logic                rd_issue;
  logic [7:0]          pend_inc;
  logic                pend_dec;

  assign cmd_len_eff = (cmd_len == '0) ? SIZE_W'(1) : cmd_len;
  // Room check is done at 9 bits so rd_pending + len cannot wrap.
  assign rd_sum      = {1'b0, rd_pending} + 9'(cmd_len_eff);
  assign rd_room     = (rd_sum <= 9'(MAX_OUTSTANDING));
  assign accept      = cmd_valid && cmd_ready;
  assign wr_beat     = (state == WR_BURST) && wr_valid && local_ready;
  assign last_beat   = wr_beat && (beat_cnt == local_size - SIZE_W'(1));
  assign rd_issue    = (state == RD_REQ) && local_ready;

  assign local_wdata = wr_data;
  assign local_be    = wr_be;
  assign busy        = (state != IDLE) || (rd_pending != '0);

  always_comb begin
    state_nx         = state;
    cmd_ready        = 1'b0;
    local_read_req   = 1'b0;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    wr_ready         = 1'b0;
    case (state)
      INIT_WAIT: begin
        if (local_init_done) state_nx = IDLE;
      end
      IDLE: begin
        cmd_ready = local_init_done && (cmd_write || rd_room);
        if (cmd_valid && cmd_ready) state_nx = cmd_write ? WR_BURST : RD_REQ;
        else if (!local_init_done)  state_nx = INIT_WAIT;
      end
      RD_REQ: begin
        local_read_req   = 1'b1;
        local_burstbegin = 1'b1;
        if (local_ready) state_nx = IDLE;
      end
      WR_BURST: begin
        local_write_req  = wr_valid;
        wr_ready         = local_ready;
        // Burst begin accompanies every offer of the first beat, including stalls.
        local_burstbegin = wr_valid && (beat_cnt == '0);
        if (last_beat) state_nx = IDLE;
      end
      default: state_nx = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= INIT_WAIT;
      local_address <= '0;
      local_size    <= '0;
      beat_cnt      <= '0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && accept) begin
        local_address <= cmd_addr;
        local_size    <= cmd_len_eff;
        beat_cnt      <= '0;
      end else if (wr_beat) begin
        beat_cnt <= beat_cnt + SIZE_W'(1);
      end
    end
  end

  // Issue and return may land in the same cycle; apply both at once.
  assign pend_inc = rd_issue ? 8'(local_size) : '0;
  assign pend_dec = local_rdata_valid && (rd_pending != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending   <= '0;
      rd_underflow <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      rd_pending <= rd_pending + pend_inc - 8'(pend_dec);
      if (local_rdata_valid && (rd_pending == '0)) rd_underflow <= 1'b1;
      rd_valid <= local_rdata_valid;
      rd_data  <= local_rdata;
    end
  end

`ifdef DDR3_MASTER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stat_rd_beats <= '0;
      stat_wr_beats <= '0;
      stat_stall    <= '0;
    end else begin
      if (local_rdata_valid) stat_rd_beats <= stat_rd_beats + 32'd1;
      if (wr_beat)           stat_wr_beats <= stat_wr_beats + 32'd1;
      if ((local_read_req || local_write_req) && !local_ready)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_local_burst_master.sv
module tb_ddr3_local_burst_master;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 256;
  localparam int SIZE_W = 5;
  localparam int MAXO   = 64;
  localparam int BE_W   = DATA_W / 8;

  logic                clk;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [SIZE_W-1:0]   cmd_len;
  logic [DATA_W-1:0]   wr_data;
  logic [BE_W-1:0]     wr_be;
  logic                wr_valid;
  logic                wr_ready;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic [7:0]          rd_pending;
  logic                rd_underflow;
  logic                busy;
  logic [ADDR_W-1:0]   local_address;
  logic [SIZE_W-1:0]   local_size;
  logic                local_burstbegin;
  logic                local_read_req;
  logic                local_write_req;
  logic [DATA_W-1:0]   local_wdata;
  logic [BE_W-1:0]     local_be;
  logic                local_ready;
  logic [DATA_W-1:0]   local_rdata;
  logic                local_rdata_valid;
  logic                local_init_done;

  ddr3_local_burst_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .SIZE_W(SIZE_W),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wr_data(wr_data),
    .wr_be(wr_be),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_pending(rd_pending),
    .rd_underflow(rd_underflow),
    .busy(busy),
    .local_address(local_address),
    .local_size(local_size),
    .local_burstbegin(local_burstbegin),
    .local_read_req(local_read_req),
    .local_write_req(local_write_req),
    .local_wdata(local_wdata),
    .local_be(local_be),
    .local_ready(local_ready),
    .local_rdata(local_rdata),
    .local_rdata_valid(local_rdata_valid),
    .local_init_done(local_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: phase 0 = waiting for calibration, 1 = idle,
  // 2 = read request outstanding on the bus, 3 = write burst.
  bit                 m_valid = 0;
  int                 m_phase;
  logic [ADDR_W-1:0]  m_addr;
  int                 m_len;
  int                 m_done;
  int                 m_pend;
  bit                 m_uf;
  bit                 m_rv;
  logic [DATA_W-1:0]  m_rd;
  int                 wr_beats_seen = 0;

  always @(negedge clk) begin
    int len_in;
    bit exp_ready;
    int inc;
    int dec;
    len_in    = (cmd_len == 0) ? 1 : int'(cmd_len);
    exp_ready = (m_phase == 1) && local_init_done && (cmd_write || (m_pend + len_in <= MAXO));
    if (m_valid) begin
      chk("cmd_ready",   cmd_ready,        exp_ready);
      chk("read_req",    local_read_req,   m_phase == 2);
      chk("write_req",   local_write_req,  (m_phase == 3) && wr_valid);
      chk("burstbegin",  local_burstbegin, (m_phase == 2) || ((m_phase == 3) && wr_valid && (m_done == 0)));
      chk("wr_ready",    wr_ready,         (m_phase == 3) && local_ready);
      chk("address",     local_address,    m_addr);
      chk("size",        local_size,       m_len);
      chk("rd_valid",    rd_valid,         m_rv);
      chk("rd_data",     rd_data,          m_rd);
      chk("rd_pending",  rd_pending,       m_pend);
      chk("rd_underflow", rd_underflow,    m_uf);
      chk("busy",        busy,             (m_phase != 1) || (m_pend != 0));
      if (m_phase == 3) begin
        chk("wdata", local_wdata, wr_data);
        chk("be",    local_be,    wr_be);
      end
    end
    if (local_write_req && local_ready) wr_beats_seen++;

    if (reset) begin
      m_valid = 1;
      m_phase = 0;
      m_addr  = '0;
      m_len   = 0;
      m_done  = 0;
      m_pend  = 0;
      m_uf    = 0;
      m_rv    = 0;
      m_rd    = '0;
    end else if (m_valid) begin
      m_rv = local_rdata_valid;
      m_rd = local_rdata;
      inc  = ((m_phase == 2) && local_ready) ? m_len : 0;
      dec  = 0;
      if (local_rdata_valid) begin
        if (m_pend == 0) m_uf = 1;
        else dec = 1;
      end
      case (m_phase)
        0: if (local_init_done) m_phase = 1;
        1: begin
          if (cmd_valid && exp_ready) begin
            m_addr  = cmd_addr;
            m_len   = len_in;
            m_done  = 0;
            m_phase = cmd_write ? 3 : 2;
          end else if (!local_init_done) begin
            m_phase = 0;
          end
        end
        2: if (local_ready) m_phase = 1;
        default: begin
          if (wr_valid && local_ready) begin
            m_done++;
            if (m_done == m_len) m_phase = 1;
          end
        end
      endcase
      m_pend = m_pend + inc - dec;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command and hold it until accepted; returns one cycle after the handshake.
  task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input logic [SIZE_W-1:0] l);
    bit ok;
    ok        = 0;
    cmd_valid = 1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      step();
    end
    chk("issue_accepted", ok, 1'b1);
    if (ok) step();
    cmd_valid = 0;
  endtask

  task automatic rd_burst(input logic [ADDR_W-1:0] a, input logic [SIZE_W-1:0] l);
    local_ready = 1;
    issue(0, a, l);
    step();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      local_rdata_valid = 1;
      local_rdata       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step();
    end
    local_rdata_valid = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d0, d1, d2, d3, pat;
    int base;
    d0  = {8{32'h1111_0000}};
    d1  = {8{32'h2222_1111}};
    d2  = {8{32'h3333_2222}};
    d3  = {8{32'h4444_3333}};
    pat = {8{32'hDEAD_BEEF}};

    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_be = '0; wr_valid = 0; local_ready = 0;
    local_rdata = '0; local_rdata_valid = 0; local_init_done = 0;
    step(); step(); step();
    chk("rst_read_req", local_read_req, 1'b0);
    chk("rst_pending",  rd_pending,     8'd0);
    chk("rst_busy",     busy,           1'b1);
    chk("rst_address",  local_address,  24'd0);
    chk("rst_underflow", rd_underflow,  1'b0);
    reset = 0;

    // Calibration gate
    local_ready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 24'h10; cmd_len = 5'd2;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("init_cmd_ready", cmd_ready, 1'b0);
      chk("init_read_req",  local_read_req, 1'b0);
      step();
    end
    local_init_done = 1;
    issue(0, 24'h10, 5'd2);
    #1;
    chk("init_read_after_accept", local_read_req, 1'b1);
    step();
    chk("init_pending", rd_pending, 8'd2);
    drain(2);

    // Write burst with a 3-cycle stall on beat 2
    local_ready = 1;
    base = wr_beats_seen;
    issue(1, 24'h000100, 5'd4);
    wr_valid = 1; wr_data = d0; wr_be = '1;
    #1;
    chk("wr_bb_first", local_burstbegin, 1'b1);
    chk("wr_req_first", local_write_req, 1'b1);
    chk("wr_addr", local_address, 24'h000100);
    chk("wr_size", local_size, 5'd4);
    step();
    wr_data = d1; local_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wr_bb_stall", local_burstbegin, 1'b0);
      chk("wr_wdata_stall", local_wdata, d1);
      chk("wr_addr_stall", local_address, 24'h000100);
      step();
    end
    local_ready = 1;
    step();
    wr_data = d2; step();
    wr_data = d3; step();
    wr_valid = 0;
    #1;
    chk("wr_beat_count", wr_beats_seen - base, 4);
    chk("wr_busy_after", busy, 1'b0);

    // Zero-length read becomes one beat
    local_ready = 1;
    issue(0, 24'h00ABCD, 5'd0);
    #1;
    chk("r0_size", local_size, 5'd1);
    chk("r0_addr", local_address, 24'h00ABCD);
    step();
    chk("r0_pending", rd_pending, 8'd1);
    local_rdata = pat; local_rdata_valid = 1;
    step();
    local_rdata_valid = 0;
    #1;
    chk("r0_rd_valid", rd_valid, 1'b1);
    chk("r0_rd_data", rd_data, pat);
    chk("r0_pending_after", rd_pending, 8'd0);
    step();
    chk("r0_rd_valid_pulse", rd_valid, 1'b0);

    // Outstanding limit
    for (int i = 0; i < 4; i++) rd_burst(24'h1000 + 24'(i * 16), 5'd16);
    #1;
    chk("lim_pending", rd_pending, 8'd64);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 24'h2000; cmd_len = 5'd16;
    for (int k = 0; k < 16; k++) begin
      local_rdata_valid = 1;
      #1;
      chk("lim_blocked", cmd_ready, 1'b0);
      step();
    end
    local_rdata_valid = 0;
    #1;
    chk("lim_pending_48", rd_pending, 8'd48);
    chk("lim_unblocked", cmd_ready, 1'b1);
    step();
    cmd_valid = 0;
    step();
    chk("lim_pending_64", rd_pending, 8'd64);
    drain(64);

    // Simultaneous issue and return, then underflow
    rd_burst(24'h3000, 5'd5);
    local_ready = 0;
    issue(0, 24'h3100, 5'd8);
    local_ready = 1; local_rdata_valid = 1;
    step();
    local_rdata_valid = 0;
    #1;
    chk("sim_pending_12", rd_pending, 8'd12);
    drain(12);
    #1;
    chk("uf_clear", rd_underflow, 1'b0);
    local_rdata_valid = 1;
    step();
    local_rdata_valid = 0;
    #1;
    chk("uf_set", rd_underflow, 1'b1);
    chk("uf_pending_zero", rd_pending, 8'd0);
    for (int k = 0; k < 5; k++) step();
    chk("uf_sticky", rd_underflow, 1'b1);

    // Reset mid-burst
    local_ready = 1;
    issue(1, 24'h004000, 5'd8);
    wr_valid = 1; wr_data = d0;
    step(); step();
    reset = 1;
    step();
    reset = 0; local_init_done = 0;
    #1;
    chk("mid_rst_write_req", local_write_req, 1'b0);
    chk("mid_rst_pending", rd_pending, 8'd0);
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_underflow", rd_underflow, 1'b0);
    wr_valid = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 24'h5000; cmd_len = 5'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("mid_rst_cmd_blocked", cmd_ready, 1'b0);
      step();
    end
    local_init_done = 1;
    #1;
    chk("mid_rst_init_cycle", cmd_ready, 1'b0);
    step();
    chk("mid_rst_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 0;
    step();
    drain(1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset             = ($urandom_range(0, 199) == 0);
      local_init_done   = ($urandom_range(0, 39) != 0);
      cmd_valid         = ($urandom_range(0, 1) == 1);
      cmd_write         = ($urandom_range(0, 1) == 1);
      cmd_addr          = ADDR_W'($urandom);
      cmd_len           = SIZE_W'($urandom_range(0, 16));
      wr_valid          = ($urandom_range(0, 9) < 7);
      wr_data           = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      wr_be             = BE_W'($urandom);
      local_ready       = ($urandom_range(0, 3) != 0);
      local_rdata       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      local_rdata_valid = (m_pend > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 0; cmd_valid = 0; wr_valid = 0; local_rdata_valid = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
